// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 single-precision square root: restoring digit recurrence,
// BPC root bits per cycle, round-to-nearest-even, denormals flushed to zero.
module fsqrt_iter #(
    parameter int BPC = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        invalid,
    output logic        udf,
    output logic        busy
);

    localparam int ITER = 26 / BPC;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [51:0] rad;
    logic [29:0] rem;
    logic [25:0] root;
    logic [7:0]  exp_r;
    logic [4:0]  cnt;
    logic        last;
    logic [31:0] y_r;
    logic        inv_r, udf_r;

    logic        x_sign;
    logic [7:0]  x_exp;
    logic [22:0] x_man;
    logic        special;
    logic [31:0] spec_y;
    logic        spec_inv, spec_udf;
    logic [51:0] rad_init;
    logic [8:0]  exp_sum;

    assign x_sign = x[31];
    assign x_exp  = x[30:23];
    assign x_man  = x[22:0];

    // Anything other than a positive normal number bypasses the recurrence.
    assign special = (x_exp == 8'h00) || (x_exp == 8'hFF) || x_sign;

    always_comb begin
        spec_y   = x;
        spec_inv = 1'b0;
        spec_udf = 1'b0;
        if (x_exp == 8'h00) begin
            spec_y   = {x_sign, 31'b0};
            spec_udf = (x_man != 23'b0);
        end else if (((x_exp == 8'hFF) && (x_man != 23'b0)) || x_sign) begin
            spec_y   = QNAN;
            spec_inv = 1'b1;
        end
    end

    // Odd unbiased exponent (even biased one) doubles the radicand into [2,4);
    // (E+127)>>1 equals floor((E-127)/2)+127.
    assign rad_init = x_exp[0] ? {2'b01, x_man, 27'b0} : {1'b1, x_man, 28'b0};
    assign exp_sum  = {1'b0, x_exp} + 9'd127;

    logic [51:0] rad_n;
    logic [29:0] rem_n, rem_sh, trial;
    logic [25:0] root_n;

    always_comb begin
        rad_n  = rad;
        rem_n  = rem;
        root_n = root;
        rem_sh = '0;
        trial  = '0;
        for (int i = 0; i < BPC; i++) begin
            rem_sh = {rem_n[27:0], rad_n[51:50]};
            trial  = {2'b00, root_n, 2'b01};
            if (rem_sh >= trial) begin
                rem_n  = rem_sh - trial;
                root_n = {root_n[24:0], 1'b1};
            end else begin
                rem_n  = rem_sh;
                root_n = {root_n[24:0], 1'b0};
            end
            rad_n = {rad_n[49:0], 2'b00};
        end
    end

    // root = 24 significand bits, guard, round; leftover remainder feeds sticky.
    logic        round_up;
    logic [24:0] sig_rnd;
    logic [31:0] rnd_y;

    always_comb begin
        round_up = root[1] & ((|rem) | root[0] | root[2]);
        sig_rnd  = {1'b0, root[25:2]} + {24'b0, round_up};
        if (sig_rnd[24])
            rnd_y = {1'b0, exp_r + 8'd1, 23'b0};
        else
            rnd_y = {1'b0, exp_r, sig_rnd[22:0]};
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = special ? DONE : CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            exp_r <= '0;
            cnt   <= '0;
            last  <= 1'b0;
            y_r   <= '0;
            inv_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (special) begin
                            y_r   <= spec_y;
                            inv_r <= spec_inv;
                            udf_r <= spec_udf;
                        end else begin
                            rad   <= rad_init;
                            rem   <= '0;
                            root  <= '0;
                            exp_r <= exp_sum[8:1];
                            cnt   <= '0;
                            last  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (last) begin
                        y_r   <= rnd_y;
                        inv_r <= 1'b0;
                        udf_r <= 1'b0;
                    end else begin
                        rad  <= rad_n;
                        rem  <= rem_n;
                        root <= root_n;
                        if (cnt == 5'(ITER - 1))
                            last <= 1'b1;
                        else
                            cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign y         = y_r;
    assign invalid   = inv_r;
    assign udf       = udf_r;

endmodule

// File: doc/fsqrt_iter.md
FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 The module SHALL have parameter BPC, default 2, meaning root bits resolved per clock cycle; the only legal values are 1 and 2.
REQ-002 The module SHALL have derived localparam ITER = 26/BPC, meaning iteration cycles per normal operand (26 or 13).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  x is presented for acceptance.
REQ-006 in_ready  output  1  unit can accept an operand this cycle.
REQ-007 x  input  32  IEEE-754 single operand.
REQ-008 out_valid  output  1  y and flags hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 y  output  32  IEEE-754 single sqrt(x), round-to-nearest-even.
REQ-011 invalid  output  1  x was negative non-zero or NaN; qualified by out_valid.
REQ-012 udf  output  1  x was denormal and was flushed to zero; qualified by out_valid.
REQ-013 busy  output  1  state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an operand is accepted on an edge where in_valid=1 and in_ready=1.
REQ-016 On acceptance of a special operand, the FSM SHALL go IDLE->DONE on that edge, so out_valid=1 one cycle after acceptance.
REQ-017 Special-operand results SHALL be: +0->+0; -0->-0; denormal(either sign)->signed zero with udf=1; +inf->+inf; NaN->0x7FC00000 with invalid=1; negative non-zero (including -inf)->0x7FC00000 with invalid=1.
REQ-018 On acceptance of a normal operand, the FSM SHALL go IDLE->CALC and register the unpacked operand.
REQ-019 Unpacking SHALL use e=E-127; the radicand is 1.m, shifted left one bit when e is odd, so it lies in [1,4).
REQ-020 Unpacking SHALL set the result exponent to floor(e/2)+127.
REQ-021 CALC SHALL run restoring digit-by-digit square root, BPC root bits per cycle, for exactly ITER cycles; an iteration counter runs 0..ITER-1 and CALC is left when it reaches ITER-1.
REQ-022 The 26 root bits SHALL comprise 24 significand bits, a guard bit and a round bit; the sticky bit is the OR of the final remainder and the round bit.
REQ-023 Rounding SHALL be nearest-even, applied on the CALC->DONE edge.
REQ-024 A rounding carry out of the significand (result 2.0) SHALL renormalise to mantissa 0 with exponent+1.
REQ-025 Normal-path latency SHALL be ITER+1 cycles from the acceptance edge to out_valid=1: 14 cycles for BPC=2, 27 cycles for BPC=1.
REQ-026 In DONE, out_valid SHALL be 1, and y, invalid and udf SHALL hold stable until the edge where out_ready=1; that edge returns the FSM to IDLE.
REQ-027 The unit SHALL NOT accept a new operand on the edge that leaves DONE; the next acceptance happens no earlier than the following cycle.
REQ-028 x and in_valid SHALL be ignored outside IDLE, and changes to x after acceptance SHALL NOT affect the result.
REQ-029 The y sign bit SHALL be 0 for all results except -0 and flushed negative denormals.
REQ-030 Overflow SHALL be impossible and no overflow flag is provided.

Reset
REQ-031 On an edge with rstn=0, state SHALL become IDLE, out_valid=0, y=0, invalid=0, udf=0, busy=0, the iteration counter 0 and the datapath registers 0.
REQ-032 On the edge where rstn returns to 1, in_ready SHALL be 1.
REQ-033 Reset asserted in CALC or DONE SHALL discard the operation, and no out_valid pulse SHALL follow after reset is released.

Verification
REQ-034 BPC=2: x=0x40800000 (4.0) accepted at edge T -> out_valid=1 after edge T+14, y=0x40000000, invalid=0, udf=0.
REQ-035 BPC=1 and BPC=2: x=0x40000000 (2.0) -> y=0x3FB504F3; x=0x3F800000 -> y=0x3F800000; latency 27 and 14 cycles respectively.
REQ-036 Special cases: x=0xBF800000 -> y=0x7FC00000 with invalid=1 one cycle after acceptance; x=0x80000000 -> y=0x80000000; x=0x00000001 -> y=0x00000000 with udf=1; x=0x7F800000 -> y=0x7F800000.
REQ-037 Backpressure: out_ready held at 0 for 5 cycles in DONE -> out_valid, y and flags stable, in_ready=0, an in_valid pulse is ignored; out_ready=1 -> IDLE next cycle.
REQ-038 Reset in CALC: rstn=0 for 1 cycle at iteration 5 -> next cycle busy=0, out_valid=0, in_ready=1, and no result emerges afterwards.
REQ-039 Random: 10^5 random normal positive x back-to-back -> y bit-exact to a round-to-nearest-even reference sqrt, and fmul(y,y) within 1 ulp of x.
